// File: rtl/xor_bist_pkg.sv
// Shared types and constants for the XOR BIST controller: FSM states and the
// four-entry test vector table.
package xor_bist_pkg;

  localparam int unsigned NUM_VEC = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_CHECK  = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  // Bit k of each table belongs to vector k: {A,B} = 00, 01, 10, 11.
  localparam logic [NUM_VEC-1:0] VEC_A = 4'b1100;
  localparam logic [NUM_VEC-1:0] VEC_B = 4'b1010;
  localparam logic [NUM_VEC-1:0] VEC_F = 4'b0110;

endpackage

// File: rtl/xor_bist_vecgen.sv
// Combinational lookup of vector k: operands A, B and the expected XOR result.
module xor_bist_vecgen
  import xor_bist_pkg::*;
(
  input  logic [1:0] k,
  output logic       a,
  output logic       b,
  output logic       f
);

  always_comb begin
    a = VEC_A[k];
    b = VEC_B[k];
    f = VEC_F[k];
  end

endmodule

// File: rtl/xor_bist_ctrl.sv
// BIST sequencer for an external XOR datapath: applies four vectors, waits SETTLE
// cycles each, checks F. Macro XOR_BIST_STOP_ON_FAIL_EN ends a run at the first mismatch.
module xor_bist_ctrl
  import xor_bist_pkg::*;
#(
  parameter int unsigned SETTLE = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       F,
  output logic       A,
  output logic       B,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] fail_cnt,
  output logic [3:0] fail_vec
);

  state_t     state, state_nx;
  logic [1:0] k, k_nx;
  logic [3:0] settle_cnt;
  logic       exp_f;
  logic       vec_a, vec_b, vec_f;
  logic       mismatch, load_vec, last_check;
  logic [2:0] cnt_after;
  logic [3:0] vec_after;

  // Looks up the vector about to be applied so operands can be registered.
  xor_bist_vecgen u_vecgen (
    .k (k_nx),
    .a (vec_a),
    .b (vec_b),
    .f (vec_f)
  );

  always_comb begin
    state_nx  = state;
    k_nx      = k;
    load_vec  = 1'b0;
    mismatch  = (state == ST_CHECK) && (F != exp_f);
    cnt_after = fail_cnt;
    vec_after = fail_vec;
    if (mismatch) begin
      cnt_after    = (fail_cnt < 3'(NUM_VEC)) ? fail_cnt + 3'd1 : fail_cnt;
      vec_after[k] = 1'b1;
    end
`ifdef XOR_BIST_STOP_ON_FAIL_EN
    last_check = mismatch || (k == 2'(NUM_VEC - 1));
`else
    last_check = (k == 2'(NUM_VEC - 1));
`endif
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_nx = ST_SETTLE;
          k_nx     = '0;
          load_vec = 1'b1;
        end
      end
      ST_SETTLE: begin
        if (settle_cnt == 4'(SETTLE - 1)) state_nx = ST_CHECK;
      end
      ST_CHECK: begin
        if (last_check) begin
          state_nx = ST_DONE;
        end else begin
          state_nx = ST_SETTLE;
          k_nx     = k + 2'd1;
          load_vec = 1'b1;
        end
      end
      ST_DONE: begin
        state_nx = ST_IDLE;
        k_nx     = '0;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      k          <= '0;
      settle_cnt <= '0;
      A          <= 1'b0;
      B          <= 1'b0;
      exp_f      <= 1'b0;
      pass       <= 1'b0;
      fail_cnt   <= '0;
      fail_vec   <= '0;
    end else begin
      state <= state_nx;
      k     <= k_nx;

      if (state == ST_IDLE && start) begin
        pass     <= 1'b0;
        fail_cnt <= '0;
        fail_vec <= '0;
      end else if (state == ST_CHECK) begin
        fail_cnt <= cnt_after;
        fail_vec <= vec_after;
        // pass must already reflect the final check during the DONE cycle
        if (state_nx == ST_DONE) pass <= (cnt_after == 3'd0);
      end

      if (load_vec) begin
        A          <= vec_a;
        B          <= vec_b;
        exp_f      <= vec_f;
        settle_cnt <= '0;
      end else begin
        if (state_nx == ST_IDLE || state_nx == ST_DONE) begin
          A <= 1'b0;
          B <= 1'b0;
        end
        if (state == ST_SETTLE) settle_cnt <= settle_cnt + 4'd1;
      end
    end
  end

  assign busy = (state == ST_SETTLE) || (state == ST_CHECK);
  assign done = (state == ST_DONE);

endmodule

// File: tb/tb_xor_bist_ctrl.sv
// Scoreboard bench for xor_bist_ctrl: the XOR datapath is a 4-entry truth table
// (correct or faulty) driven by A/B; a reference model predicts each run's result.
module tb_xor_bist_ctrl;

  localparam int unsigned SET = 2;

  typedef struct {
    int s;
    int done_cyc;
    int pass;
    int cnt;
    int vec;
  } exp_t;

  logic       clk, rst, start, F, A, B, busy, done, pass;
  logic [2:0] fail_cnt;
  logic [3:0] fail_vec;
  logic [3:0] tt;

  int   tests = 0;
  int   fails = 0;
  int   edges = 0;
  exp_t sb[$];

  xor_bist_ctrl #(.SETTLE(SET)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .F        (F),
    .A        (A),
    .B        (B),
    .busy     (busy),
    .done     (done),
    .pass     (pass),
    .fail_cnt (fail_cnt),
    .fail_vec (fail_vec)
  );

  assign F = tt[{A, B}];

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) edges <= edges + 1;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: vector k applies A=k[1], B=k[0]; a good datapath gives A^B.
  function automatic exp_t model(input logic [3:0] table_v);
    exp_t e;
    e.cnt      = 0;
    e.vec      = 0;
    e.done_cyc = NUM_DONE();
    for (int k = 0; k < 4; k++) begin
      int golden;
      golden = ((k >> 1) ^ k) & 1;
      if (int'(table_v[k]) != golden) begin
        e.cnt++;
        e.vec |= (1 << k);
`ifdef XOR_BIST_STOP_ON_FAIL_EN
        e.done_cyc = (k + 1) * (SET + 1) + 1;
        break;
`endif
      end
    end
    e.pass = (e.cnt == 0) ? 1 : 0;
    e.s    = 0;
    return e;
  endfunction

  function automatic int NUM_DONE();
    return 4 * (SET + 1) + 1;
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      if (done) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("done_cycle", edges - e.s + 1, e.done_cyc);
          chk("pass", int'(pass), e.pass);
          chk("fail_cnt", int'(fail_cnt), e.cnt);
          chk("fail_vec", int'(fail_vec), e.vec);
          chk("ab_in_done", int'({A, B}), 0);
          chk("busy_in_done", int'(busy), 0);
        end
      end else if (sb.size() != 0) begin
        int c;
        c = edges - sb[0].s + 1;
        if (c >= 1 && c < sb[0].done_cyc) chk("busy_in_run", int'(busy), 1);
      end
    end
  end

  task automatic run(input logic [3:0] table_v, input bit restart);
    exp_t e;
    e   = model(table_v);
    tt  = table_v;
    e.s = edges + 1;
    sb.push_back(e);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (restart) begin
      repeat (4) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      chk("done_timeout", 0, 1);
      sb.delete();
    end
    repeat (3) @(negedge clk);
    chk("hold_pass", int'(pass), e.pass);
    chk("hold_cnt", int'(fail_cnt), e.cnt);
    chk("hold_vec", int'(fail_vec), e.vec);
    chk("hold_done", int'(done), 0);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_ab"}, int'({A, B}), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_pass"}, int'(pass), 0);
    chk({tag, "_cnt"}, int'(fail_cnt), 0);
    chk({tag, "_vec"}, int'(fail_vec), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    tt    = 4'b0110;
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    rst = 1'b0;
    @(negedge clk);

    run(4'b0110, 1'b0);   // correct XOR
    run(4'b0000, 1'b0);   // F stuck-at-0
    run(4'b1110, 1'b0);   // OR instead of XOR
    run(4'b1111, 1'b0);   // F stuck-at-1
    run(4'b0110, 1'b1);   // start re-asserted mid-run

    // Reset during a run: outputs clear at once and no done pulse follows.
    tt    = 4'b0000;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    #2 rst = 1'b1;
    #1 check_reset_vals("abort");
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    run(4'b0110, 1'b0);

    for (int n = 0; n < 20; n++) begin
      logic [3:0] r;
      r = 4'($urandom_range(0, 15));
      repeat ($urandom_range(0, 3)) @(negedge clk);
      run(r, 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/xor_bist_ctrl.md
XOR_BIST_CTRL -- requirements
Module: xor_bist_ctrl

Interface
REQ-001 SHALL have parameter SETTLE, default 2, meaning cycles vector is held before F is sampled; legal range 1..15.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port start  input  1  run request; sampled only in IDLE.
REQ-005 SHALL have port F  input  1  result from external XOR datapath under test.
REQ-006 SHALL have ports A, B  output  1 each  registered operands driven to the XOR datapath.
REQ-007 SHALL have port busy  output  1  high while a run is in progress (SETTLE, CHECK).
REQ-008 SHALL have port done  output  1  one-cycle pulse at end of run.
REQ-009 SHALL have port pass  output  1  high iff last completed run had zero mismatches.
REQ-010 SHALL have port fail_cnt  output  3  mismatch count of current/last run, 0..4.
REQ-011 SHALL have port fail_vec  output  4  bit k set iff vector k mismatched.

Function
REQ-012 SHALL use vector order k=0..3: {A,B} = 00, 01, 10, 11, with expected F = 0, 1, 1, 0.
REQ-013 SHALL implement FSM states IDLE, SETTLE, CHECK, DONE.
REQ-014 SHALL, in IDLE with start=1 at cycle 0, clear pass, fail_cnt and fail_vec, and enter SETTLE with {A,B}=vector 0 at cycle 1.
REQ-015 SHALL remain in SETTLE for exactly SETTLE cycles, holding A and B stable, then enter CHECK.
REQ-016 SHALL, in CHECK, compare F with the expected value; on mismatch it increments fail_cnt and sets fail_vec[k].
REQ-017 SHALL, from CHECK with k<3, advance k and drive the next vector in the following cycle (SETTLE).
REQ-018 SHALL, from CHECK with k=3, enter DONE.
REQ-019 SHALL give vector k a CHECK cycle of (k+1)*(SETTLE+1) and a DONE cycle of 4*(SETTLE+1)+1, counted from the start cycle.
REQ-020 SHALL occupy DONE for one cycle: done=1; pass = (fail_cnt==0), including that cycle's result; next state IDLE.
REQ-021 SHALL drive A=B=0 in IDLE and DONE.
REQ-022 SHALL ignore start while busy or in DONE; no restart and no result change.
REQ-023 SHALL hold pass, fail_cnt and fail_vec stable from DONE until the next accepted start.
REQ-024 SHALL not let fail_cnt wrap; maximum value is 4.

Reset
REQ-025 SHALL, on rst=1 at any time including mid-run, immediately force IDLE, k=0, A=B=0, busy=0, done=0, pass=0, fail_cnt=0, fail_vec=0000.
REQ-026 SHALL not emit a done pulse for a run aborted by reset.

Configuration
REQ-027 SHALL recognise macro XOR_BIST_STOP_ON_FAIL_EN: when defined, the first mismatch in CHECK goes directly to DONE, leaving fail_cnt=1 and exactly one fail_vec bit set.
REQ-028 SHALL, without XOR_BIST_STOP_ON_FAIL_EN, always check all four vectors regardless of mismatches.

Structure
REQ-029 SHALL place the FSM state encoding, vector table (operands and expected F) and NUM_VEC=4 in shared package xor_bist_pkg.
REQ-030 SHALL use one sub-module, xor_bist_vecgen: combinational map from k to {A,B,expected F}.
REQ-031 SHALL instantiate no XOR datapath internally; the bench connects xora to A, B and F.

Verification (SETTLE=2)
REQ-032 SHALL cover: correct xora, start at cycle 0 -> CHECKs at 3,6,9,12; done at cycle 13; pass=1, fail_cnt=0, fail_vec=0000.
REQ-033 SHALL cover: F stuck-at-0 -> done at 13; pass=0, fail_cnt=2, fail_vec=0110.
REQ-034 SHALL cover: OR model in place of XOR (F=A|B) -> pass=0, fail_cnt=1, fail_vec=1000.
REQ-035 SHALL cover: XOR_BIST_STOP_ON_FAIL_EN with F stuck-at-1 -> done at cycle 4; fail_cnt=1, fail_vec=0001.
REQ-036 SHALL cover: rst pulse at cycle 7 during a run -> all outputs at reset values, no done pulse; a new start then completes with pass=1.
REQ-037 SHALL cover: start asserted again at cycle 5 mid-run -> ignored; done still at cycle 13 with unchanged results.
